video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Core-side raster timing generator feeding arcade_video: derives the pixel
//  clock enable from clk_video and produces pixel/line counters, blanking and
//  sync. Sync position is user-adjustable (OSD screen centring). The offsets
//  are applied only at frame boundaries, so a frame never tears.
// PARAMETERS
//  CE_DIV        2    clk_video cycles per pixel (>=2)
//  H_TOTAL       384  pixels per line
//  H_VIS         320  visible pixels (hcount 0..H_VIS-1)
//  H_SYNC_START  336  nominal HSync start pixel
//  H_SYNC_LEN    32   HSync width, pixels
//  V_TOTAL       262  lines per frame
//  V_VIS         240  visible lines (vcount 0..V_VIS-1)
//  V_SYNC_START  244  nominal VSync start line
//  V_SYNC_LEN    3    VSync width, lines
//  HW / VW       9/9  hcount / vcount widths
// PORTS
//  clk_video    in   1   video clock
//  reset_n      in   1   async active-low reset
//  h_offset     in   4   signed HSync shift, pixels (-8..+7)
//  v_offset     in   4   signed VSync shift, lines (-8..+7)
//  ce_pix       out  1   one-clk pixel enable, period CE_DIV
//  hcount       out  HW  current pixel
//  vcount       out  VW  current line
//  HBlank       out  1   high when hcount >= H_VIS
//  VBlank       out  1   high when vcount >= V_VIS
//  HSync        out  1   active-high
//  VSync        out  1   active-high
//  frame_start  out  1   one-clk pulse with ce_pix when (hcount,vcount) becomes (0,0)
// BEHAVIOUR
//  - Reset (async assert, sync release): div=0, hcount=vcount=0, all 1-bit
//    outputs 0, latched offsets 0.
//  - div counts 0..CE_DIV-1 and wraps. adv = (div==CE_DIV-1).
//  - On adv: hcount+1, wrapping H_TOTAL-1 -> 0. On that wrap, vcount+1,
//    wrapping V_TOTAL-1 -> 0. HBlank, VBlank, HSync, VSync and frame_start
//    are registered on the same edge. They are decoded from the NEXT counter
//    values, so every output is mutually consistent in any cycle.
//  - ce_pix <= adv. It is high the cycle after the update, while the values
//    are stable. No other pipelining.
//  - Offsets: h_offset/v_offset are sampled into internal regs on the adv
//    where hcount=H_TOTAL-1 and vcount=V_TOTAL-1. They take effect from
//    pixel (0,0). Changes mid-frame are ignored until then.
//  - hs = (H_SYNC_START + h_off) mod H_TOTAL, computed in HW+2 signed.
//    HSync is high for H_SYNC_LEN pixels starting at hs, with a circular
//    window (wraps past H_TOTAL-1 to 0). VSync works the same way with
//    vs/V_TOTAL/V_SYNC_LEN, on line granularity.
//  - VSync toggles only at the hcount wrap, so its edges coincide with the
//    line change.
//  - frame_start rises on every adv that wraps both counters. It is also
//    never asserted during reset.
//  - Offsets may push sync into the visible area. There is no clamping;
//    this is intended.
//  - Reset mid-frame: all outputs return to reset values immediately. The
//    first frame after release starts at (0,0) but does not pulse
//    frame_start until the first full wrap.
// TESTING
//  1 reset_n low -> ce_pix/HBlank/VBlank/HSync/VSync/frame_start=0,
//    hcount=vcount=0.
//  2 Release, CE_DIV=2 -> ce_pix high every 2nd clk. hcount 0..383 repeats,
//    line period 768 clk.
//  3 Defaults, offsets 0 -> HBlank for hcount 320..383. HSync for hcount
//    336..367. VBlank for vcount 240..261. VSync for vcount 244..246.
//  4 Free-run -> frame_start exactly once per 384*262*2=201216 clk, at
//    hcount=vcount=0.
//  5 h_offset=+4 set at vcount=100 -> current frame HSync stays 336..367.
//    Next frame HSync is 340..371. v_offset=-8 -> next frame VSync on
//    lines 236..238.
//  6 H_SYNC_START=382, H_SYNC_LEN=4 -> HSync on hcount 382,383,0,1.
//    Async reset pulse mid-line -> outputs zero within the same cycle.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel enable, counters, blanking, sync.
// Sync start shifts by frame-latched offsets so a frame never tears.
module video_timing_gen #(
  parameter int CE_DIV       = 2,
  parameter int H_TOTAL      = 384,
  parameter int H_VIS        = 320,
  parameter int H_SYNC_START = 336,
  parameter int H_SYNC_LEN   = 32,
  parameter int V_TOTAL      = 262,
  parameter int V_VIS        = 240,
  parameter int V_SYNC_START = 244,
  parameter int V_SYNC_LEN   = 3,
  parameter int HW           = 9,
  parameter int VW           = 9
) (
  input  logic          clk_video,
  input  logic          reset_n,
  input  logic [3:0]    h_offset,
  input  logic [3:0]    v_offset,
  output logic          ce_pix,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          HBlank,
  output logic          VBlank,
  output logic          HSync,
  output logic          VSync,
  output logic          frame_start
);

  localparam int DW = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;

  localparam logic signed [HW+1:0] HT_S =
    (HW+2)'(H_TOTAL);
  localparam logic signed [HW+1:0] HS_S =
    (HW+2)'(H_SYNC_START);
  localparam logic signed [HW+1:0] HL_S =
    (HW+2)'(H_SYNC_LEN);
  localparam logic signed [VW+1:0] VT_S =
    (VW+2)'(V_TOTAL);
  localparam logic signed [VW+1:0] VS_S =
    (VW+2)'(V_SYNC_START);
  localparam logic signed [VW+1:0] VL_S =
    (VW+2)'(V_SYNC_LEN);

  logic [DW-1:0] div;
  logic [3:0]    h_off;
  logic [3:0]    v_off;

  logic          adv;
  logic          h_last;
  logic          v_last;
  logic          f_wrap;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic [3:0]    h_off_n;
  logic [3:0]    v_off_n;

  logic signed [HW+1:0] hs_raw;
  logic signed [HW+1:0] hs;
  logic signed [HW+1:0] hd;
  logic signed [VW+1:0] vs_raw;
  logic signed [VW+1:0] vs;
  logic signed [VW+1:0] vd;

  logic hblank_n;
  logic vblank_n;
  logic hsync_n;
  logic vsync_n;

  // next counter values and frame-boundary offset selection
  always_comb begin
    adv     = (div == DW'(CE_DIV - 1));
    h_last  = (hcount == HW'(H_TOTAL - 1));
    v_last  = (vcount == VW'(V_TOTAL - 1));
    f_wrap  = h_last & v_last;
    h_nxt   = h_last ? '0 : hcount + 1'b1;
    v_nxt   = vcount;
    if (h_last)
      v_nxt = v_last ? '0 : vcount + 1'b1;
    h_off_n = f_wrap ? h_offset : h_off;
    v_off_n = f_wrap ? v_offset : v_off;
  end

  // circular sync windows decoded from the next position
  always_comb begin
    hs_raw = HS_S +
      {{(HW-2){h_off_n[3]}}, h_off_n};
    hs = hs_raw;
    if (hs_raw[HW+1])
      hs = hs_raw + HT_S;
    else if (hs_raw >= HT_S)
      hs = hs_raw - HT_S;
    hd = $signed({2'b00, h_nxt}) - hs;
    if (hd[HW+1])
      hd = hd + HT_S;
    hsync_n = (hd < HL_S);

    vs_raw = VS_S +
      {{(VW-2){v_off_n[3]}}, v_off_n};
    vs = vs_raw;
    if (vs_raw[VW+1])
      vs = vs_raw + VT_S;
    else if (vs_raw >= VT_S)
      vs = vs_raw - VT_S;
    vd = $signed({2'b00, v_nxt}) - vs;
    if (vd[VW+1])
      vd = vd + VT_S;
    vsync_n = (vd < VL_S);

    hblank_n = (h_nxt >= HW'(H_VIS));
    vblank_n = (v_nxt >= VW'(V_VIS));
  end

  // divider, counters and all registered outputs
  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      div         <= '0;
      hcount      <= '0;
      vcount      <= '0;
      h_off       <= '0;
      v_off       <= '0;
      ce_pix      <= 1'b0;
      HBlank      <= 1'b0;
      VBlank      <= 1'b0;
      HSync       <= 1'b0;
      VSync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= adv ? '0 : div + 1'b1;
      ce_pix      <= adv;
      frame_start <= adv & f_wrap;
      if (adv) begin
        hcount <= h_nxt;
        vcount <= v_nxt;
        HBlank <= hblank_n;
        VBlank <= vblank_n;
        HSync  <= hsync_n;
        if (h_last)
          VSync <= vsync_n;
        if (f_wrap) begin
          h_off <= h_offset;
          v_off <= v_offset;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default raster,
// a small raster for frame/offset behaviour, and a wrapped HSync.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got,
                     input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int inwin(int c, int s, int len,
                               int tot);
    int d;
    d = c - s;
    d = ((d % tot) + tot) % tot;
    return (d < len) ? 1 : 0;
  endfunction

  // instance A: default raster
  logic       rst_a = 1'b0;
  logic [3:0] ho_a = 4'h0;
  logic [3:0] vo_a = 4'h0;
  logic       ce_a, hb_a, vb_a, hs_a, vs_a, fs_a;
  logic [8:0] hc_a, vc_a;

  video_timing_gen u_a (
    .clk_video(clk), .reset_n(rst_a),
    .h_offset(ho_a), .v_offset(vo_a),
    .ce_pix(ce_a), .hcount(hc_a), .vcount(vc_a),
    .HBlank(hb_a), .VBlank(vb_a),
    .HSync(hs_a), .VSync(vs_a),
    .frame_start(fs_a)
  );

  // instance B: 16x20 raster, 640 clk per frame
  logic       rst_b = 1'b0;
  logic [3:0] ho_b = 4'h0;
  logic [3:0] vo_b = 4'h0;
  logic       ce_b, hb_b, vb_b, hs_b, vs_b, fs_b;
  logic [8:0] hc_b, vc_b;

  video_timing_gen #(
    .H_TOTAL(16), .H_VIS(10),
    .H_SYNC_START(12), .H_SYNC_LEN(3),
    .V_TOTAL(20), .V_VIS(14),
    .V_SYNC_START(16), .V_SYNC_LEN(2)
  ) u_b (
    .clk_video(clk), .reset_n(rst_b),
    .h_offset(ho_b), .v_offset(vo_b),
    .ce_pix(ce_b), .hcount(hc_b), .vcount(vc_b),
    .HBlank(hb_b), .VBlank(vb_b),
    .HSync(hs_b), .VSync(vs_b),
    .frame_start(fs_b)
  );

  // instance C: HSync wrapping past the line end
  logic       rst_c = 1'b0;
  logic [3:0] ho_c = 4'h0;
  logic [3:0] vo_c = 4'h0;
  logic       ce_c, hb_c, vb_c, hs_c, vs_c, fs_c;
  logic [8:0] hc_c, vc_c;

  video_timing_gen #(
    .H_SYNC_START(382), .H_SYNC_LEN(4)
  ) u_c (
    .clk_video(clk), .reset_n(rst_c),
    .h_offset(ho_c), .v_offset(vo_c),
    .ce_pix(ce_c), .hcount(hc_c), .vcount(vc_c),
    .HBlank(hb_c), .VBlank(vb_c),
    .HSync(hs_c), .VSync(vs_c),
    .frame_start(fs_c)
  );

  function automatic logic ce_of(int s);
    case (s)
      0:       return ce_a;
      1:       return ce_b;
      default: return ce_c;
    endcase
  endfunction

  task automatic wait_ce(input int s);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ce_of(s) && n < 8);
    if (!ce_of(s))
      chk("ce_timeout", 0, 1);
  endtask

  initial begin
    int eh, ev, last, wrap_cyc, fs_cnt, fs_last;
    int mho, mvo, frame;
    bit set_done;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ce", ce_a, 0);
    chk("rst_hc", hc_a, 0);
    chk("rst_vc", vc_a, 0);
    chk("rst_hb", hb_a, 0);
    chk("rst_vb", vb_a, 0);
    chk("rst_hs", hs_a, 0);
    chk("rst_vs", vs_a, 0);
    chk("rst_fs", fs_a, 0);

    // A: two lines of default raster
    rst_a = 1'b1;
    eh = 0;
    last = -1;
    wrap_cyc = -1;
    for (int i = 0; i < 768; i++) begin
      wait_ce(0);
      eh = (eh + 1) % 384;
      if (i < 4 && last >= 0)
        chk("a_ce_period", cyc - last, 2);
      last = cyc;
      chk("a_hc", hc_a, eh);
      chk("a_hb", hb_a, (eh >= 320) ? 1 : 0);
      chk("a_hs", hs_a,
          (eh >= 336 && eh <= 367) ? 1 : 0);
      chk("a_fs", fs_a, 0);
      if (eh == 0) begin
        chk("a_vc", vc_a, (i < 384) ? 1 : 2);
        chk("a_vb", vb_a, 0);
        chk("a_vs", vs_a, 0);
        if (wrap_cyc >= 0)
          chk("a_line_period", cyc - wrap_cyc, 768);
        wrap_cyc = cyc;
      end
    end

    // B: three frames, offsets changed mid-frame
    rst_b = 1'b1;
    eh = 0;
    ev = 0;
    mho = 0;
    mvo = 0;
    frame = 0;
    fs_cnt = 0;
    fs_last = -1;
    set_done = 1'b0;
    for (int i = 0; i < 960; i++) begin
      wait_ce(1);
      eh = (eh + 1) % 16;
      if (eh == 0)
        ev = (ev + 1) % 20;
      if (eh == 0 && ev == 0) begin
        mho = int'($signed(ho_b));
        mvo = int'($signed(vo_b));
        frame++;
        set_done = 1'b0;
      end
      chk("b_hc", hc_b, eh);
      chk("b_vc", vc_b, ev);
      chk("b_hb", hb_b, (eh >= 10) ? 1 : 0);
      chk("b_vb", vb_b, (ev >= 14) ? 1 : 0);
      chk("b_hs", hs_b, inwin(eh, 12 + mho, 3, 16));
      chk("b_vs", vs_b, inwin(ev, 16 + mvo, 2, 20));
      chk("b_fs", fs_b,
          (eh == 0 && ev == 0) ? 1 : 0);
      if (fs_b) begin
        fs_cnt++;
        if (fs_last >= 0)
          chk("b_frame_period", cyc - fs_last, 640);
        fs_last = cyc;
      end
      if (ev == 5 && eh == 3 && !set_done) begin
        set_done = 1'b1;
        if (frame == 0) begin
          ho_b = 4'h2;
          vo_b = 4'h8;
        end else if (frame == 1) begin
          ho_b = 4'hD;
        end
      end
    end
    chk("b_fs_count", fs_cnt, 3);

    // C: HSync on 382,383,0,1
    rst_c = 1'b1;
    eh = 0;
    for (int i = 0; i < 385; i++) begin
      wait_ce(2);
      eh = (eh + 1) % 384;
      chk("c_hc", hc_c, eh);
      chk("c_hs", hs_c,
          (eh >= 382 || eh <= 1) ? 1 : 0);
    end

    // C: async reset mid-line, before any clock edge
    #2 rst_c = 1'b0;
    #1;
    chk("c_rst_hc", hc_c, 0);
    chk("c_rst_vc", vc_c, 0);
    chk("c_rst_ce", ce_c, 0);
    chk("c_rst_hs", hs_c, 0);
    chk("c_rst_hb", hb_c, 0);
    chk("c_rst_fs", fs_c, 0);
    repeat (3) @(negedge clk);
    rst_c = 1'b1;
    wait_ce(2);
    chk("c_rel_hc", hc_c, 1);
    chk("c_rel_fs", fs_c, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
